// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU / loader arbiter for the unified memory data port
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default build gives ties to the CPU.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module mem_port_arbiter #(
  parameter int MAX_LOCK = 16,
  parameter int CNT_W    = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic                   cpu_lock,
  input  logic [`WORD_WIDTH-1:0] cpu_addr,
  input  logic [`WORD_WIDTH-1:0] cpu_wdata,
  output logic                   cpu_gnt,
  output logic                   cpu_rvalid,
  output logic [`WORD_WIDTH-1:0] cpu_rdata,
  input  logic                   ldr_req,
  input  logic                   ldr_we,
  input  logic                   ldr_lock,
  input  logic [`WORD_WIDTH-1:0] ldr_addr,
  input  logic [`WORD_WIDTH-1:0] ldr_wdata,
  output logic                   ldr_gnt,
  output logic                   ldr_rvalid,
  output logic [`WORD_WIDTH-1:0] ldr_rdata,
  output logic [`WORD_WIDTH-1:0] mem_addr,
  output logic [`WORD_WIDTH-1:0] mem_wdata,
  output logic                   mem_we,
  input  logic [`WORD_WIDTH-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_LOCK - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_LDR = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         lock_cnt_q, lock_cnt_d;
  logic                     cpu_rvalid_q, ldr_rvalid_q;
  logic [`WORD_WIDTH-1:0]   cpu_rdata_q, ldr_rdata_q;
  logic                     tie_to_cpu;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Set when the CPU was the most recent side to take ownership.
  logic last_cpu_q, last_cpu_d;

  assign tie_to_cpu = !last_cpu_q;

  always_comb begin
    last_cpu_d = last_cpu_q;
    if (state_d == OWN_CPU)      last_cpu_d = 1'b1;
    else if (state_d == OWN_LDR) last_cpu_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_cpu_q <= 1'b0;
    else        last_cpu_q <= last_cpu_d;
  end
`else
  assign tie_to_cpu = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = '0;
    cpu_gnt    = 1'b0;
    ldr_gnt    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req && (!ldr_req || tie_to_cpu)) state_d = OWN_CPU;
        else if (ldr_req)                        state_d = OWN_LDR;
      end
      OWN_CPU: begin
        cpu_gnt   = cpu_req;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we && cpu_req;
        // A locked owner keeps the port until it has used the cap while the rival waits.
        if (cpu_req && cpu_lock && !(ldr_req && lock_cnt_q == CNT_CAP)) begin
          lock_cnt_d = (lock_cnt_q == CNT_CAP) ? lock_cnt_q : lock_cnt_q + 1'b1;
        end else if (ldr_req) begin
          state_d = OWN_LDR;
        end else if (!cpu_req) begin
          state_d = IDLE;
        end
      end
      OWN_LDR: begin
        ldr_gnt   = ldr_req;
        mem_addr  = ldr_addr;
        mem_wdata = ldr_wdata;
        mem_we    = ldr_we && ldr_req;
        if (ldr_req && ldr_lock && !(cpu_req && lock_cnt_q == CNT_CAP)) begin
          lock_cnt_d = (lock_cnt_q == CNT_CAP) ? lock_cnt_q : lock_cnt_q + 1'b1;
        end else if (cpu_req) begin
          state_d = OWN_CPU;
        end else if (!ldr_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lock_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      cpu_rvalid_q <= cpu_gnt && !cpu_we;
      ldr_rvalid_q <= ldr_gnt && !ldr_we;
      if (cpu_gnt && !cpu_we) cpu_rdata_q <= mem_rdata;
      if (ldr_gnt && !ldr_we) ldr_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign ldr_rvalid = ldr_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ldr_rdata  = ldr_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized bench for mem_port_arbiter
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module tb_mem_port_arbiter;
  localparam int W        = `WORD_WIDTH;
  localparam int MAX_LOCK = 16;
  localparam int DEPTH    = 1024;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_req = 1'b0, cpu_we = 1'b0, cpu_lock = 1'b0;
  logic [W-1:0] cpu_addr = '0, cpu_wdata = '0;
  logic         cpu_gnt, cpu_rvalid;
  logic [W-1:0] cpu_rdata;
  logic         ldr_req = 1'b0, ldr_we = 1'b0, ldr_lock = 1'b0;
  logic [W-1:0] ldr_addr = '0, ldr_wdata = '0;
  logic         ldr_gnt, ldr_rvalid;
  logic [W-1:0] ldr_rdata;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         mem_we;

  logic [W-1:0] mem [DEPTH] = '{default: '0};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: owner -1 = nobody, 0 = CPU, 1 = loader.
  int           m_owner;
  int           m_run;
  bit           m_rv [2];
  logic [W-1:0] m_rd [2];
  logic [W-1:0] exp_mem [DEPTH] = '{default: '0};
`ifdef MEM_ARB_ROUND_ROBIN_EN
  int           m_last;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_LOCK(MAX_LOCK), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock),
    .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;

  function automatic bit exp_gnt(int s);
    return (m_owner == s) && ((s == 0) ? cpu_req : ldr_req);
  endfunction

  function automatic logic [2*W:0] exp_bus();
    if (m_owner == 0) return {cpu_req & cpu_we, cpu_addr, cpu_wdata};
    if (m_owner == 1) return {ldr_req & ldr_we, ldr_addr, ldr_wdata};
    return '0;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_run   = 0;
    m_rv[0] = 0; m_rv[1] = 0;
    m_rd[0] = '0; m_rd[1] = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    m_last  = 1;
`endif
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_clock();
    bit r [2], w [2], l [2];
    logic [W-1:0] a [2], d [2];
    int nxt, o, x;
    r[0] = cpu_req; w[0] = cpu_we; l[0] = cpu_lock; a[0] = cpu_addr; d[0] = cpu_wdata;
    r[1] = ldr_req; w[1] = ldr_we; l[1] = ldr_lock; a[1] = ldr_addr; d[1] = ldr_wdata;
    m_rv[0] = 0; m_rv[1] = 0;
    if (m_owner >= 0 && r[m_owner]) begin
      if (w[m_owner]) exp_mem[a[m_owner][9:0]] = d[m_owner];
      else begin
        m_rv[m_owner] = 1;
        m_rd[m_owner] = exp_mem[a[m_owner][9:0]];
      end
    end
    if (m_owner < 0) begin
      if (r[0] && r[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        nxt = 1 - m_last;
`else
        nxt = 0;
`endif
      end else if (r[0]) nxt = 0;
      else if (r[1])     nxt = 1;
      else               nxt = -1;
      m_run = 0;
    end else begin
      o = m_owner; x = 1 - o;
      if (r[o] && l[o] && !(r[x] && m_run >= MAX_LOCK - 1)) begin
        nxt = o;
        if (m_run < MAX_LOCK - 1) m_run++;
      end else begin
        m_run = 0;
        if (r[x])      nxt = x;
        else if (r[o]) nxt = o;
        else           nxt = -1;
      end
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (nxt >= 0) m_last = nxt;
`endif
    m_owner = nxt;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_lock = 0; ldr_req = 0; ldr_we = 0; ldr_lock = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_clock();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; cpu_req = 1; cpu_we = 1; ldr_req = 1;
    model_reset();
    @(negedge clk); #1;
    n_checks++; if (cpu_gnt !== 1'b0) $display("FAIL reset_cpu_gnt got=%b exp=0", cpu_gnt); else n_pass++;
    n_checks++; if (ldr_gnt !== 1'b0) $display("FAIL reset_ldr_gnt got=%b exp=0", ldr_gnt); else n_pass++;
    n_checks++; if ({cpu_rvalid, ldr_rvalid} !== 2'b00) $display("FAIL reset_rvalid got=%b exp=00", {cpu_rvalid, ldr_rvalid}); else n_pass++;
    n_checks++; if (cpu_rdata !== '0 || ldr_rdata !== '0) $display("FAIL reset_rdata got=%h/%h exp=0/0", cpu_rdata, ldr_rdata); else n_pass++;
    n_checks++; if (mem_we !== 1'b0 || mem_addr !== '0) $display("FAIL reset_mem got we=%b addr=%h exp 0/0", mem_we, mem_addr); else n_pass++;
    cpu_req = 0; cpu_we = 0; ldr_req = 0; rst_n = 1'b1;
    model_clock();
  endtask

  task automatic test_write_read();
    apply_reset();
    @(negedge clk); cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF; #1;
    n_checks++; if (cpu_gnt !== 1'b0) $display("FAIL wr_latency got=%b exp=0", cpu_gnt); else n_pass++;
    model_clock();
    @(negedge clk); #1;
    n_checks++; if ({cpu_gnt, mem_we, mem_addr} !== {2'b11, 16'h0010}) $display("FAIL wr_gnt got=%b%b %h exp=11 0010", cpu_gnt, mem_we, mem_addr); else n_pass++;
    model_clock();
    @(negedge clk); cpu_we = 0; #1;
    n_checks++; if (mem[16] !== 16'hBEEF) $display("FAIL wr_mem got=%h exp=beef", mem[16]); else n_pass++;
    n_checks++; if ({cpu_gnt, mem_we} !== 2'b10) $display("FAIL rd_gnt got=%b exp=10", {cpu_gnt, mem_we}); else n_pass++;
    model_clock();
    @(negedge clk); cpu_req = 0; #1;
    n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hBEEF) $display("FAIL rd_data got=%b %h exp=1 beef", cpu_rvalid, cpu_rdata); else n_pass++;
    model_clock();
    @(negedge clk); #1;
    n_checks++; if (cpu_rvalid !== 1'b0) $display("FAIL rd_rvalid_pulse got=%b exp=0", cpu_rvalid); else n_pass++;
    model_clock();
  endtask

  task automatic test_tie();
    bit cpu_done = 0, ldr_done = 0, cg = 0, lg = 0;
    int first = -1;
    apply_reset();
    cpu_we = 0; ldr_we = 0; cpu_lock = 0; ldr_lock = 0;
    cpu_addr = 16'h0010; ldr_addr = 16'h0011;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (cg) cpu_done = 1;
      if (lg) ldr_done = 1;
      cpu_req = !cpu_done; ldr_req = !ldr_done; #1;
      n_checks++; if ({cpu_gnt, ldr_gnt} !== {exp_gnt(0), exp_gnt(1)}) $display("FAIL tie_gnt cyc=%0d got=%b exp=%b", c, {cpu_gnt, ldr_gnt}, {exp_gnt(0), exp_gnt(1)}); else n_pass++;
      n_checks++; if (cpu_gnt && ldr_gnt) $display("FAIL tie_overlap cyc=%0d got=11 exp=not both", c); else n_pass++;
      n_checks++; if ({cpu_rvalid, ldr_rvalid} !== {m_rv[0], m_rv[1]}) $display("FAIL tie_rvalid cyc=%0d got=%b exp=%b%b", c, {cpu_rvalid, ldr_rvalid}, m_rv[0], m_rv[1]); else n_pass++;
      if (first < 0 && cpu_gnt) first = 0;
      else if (first < 0 && ldr_gnt) first = 1;
      cg = cpu_gnt; lg = ldr_gnt;
      model_clock();
    end
    n_checks++; if (first !== 0) $display("FAIL tie_first got=%0d exp=0", first); else n_pass++;
    n_checks++; if (!(cpu_done && ldr_done)) $display("FAIL tie_both_served got=%b%b exp=11", cpu_done, ldr_done); else n_pass++;
  endtask

  task automatic test_lock_cap();
    int i = 0, ldr_before = 0, cyc = 0;
    bit cpu_served = 0;
    apply_reset();
    cpu_addr = 16'h0050; cpu_we = 0; cpu_lock = 0;
    ldr_we = 1; ldr_lock = 1;
    @(negedge clk); ldr_req = 1; ldr_addr = 16'h0100; ldr_wdata = 16'hA000; #1;
    model_clock();
    while (i < 40 && cyc < 200) begin
      @(negedge clk);
      cpu_req = !cpu_served;
      ldr_addr = W'(16'h0100 + i); ldr_wdata = W'(16'hA000 + i); #1;
      n_checks++; if ({cpu_gnt, ldr_gnt} !== {exp_gnt(0), exp_gnt(1)}) $display("FAIL cap_gnt cyc=%0d got=%b exp=%b", cyc, {cpu_gnt, ldr_gnt}, {exp_gnt(0), exp_gnt(1)}); else n_pass++;
      if (ldr_gnt) begin
        i++;
        if (!cpu_served) ldr_before++;
      end
      if (cpu_gnt) cpu_served = 1;
      model_clock();
      cyc++;
    end
    @(negedge clk); ldr_req = 0; cpu_req = 0; ldr_lock = 0; #1;
    model_clock();
    n_checks++; if (ldr_before !== 16) $display("FAIL cap_ldr_run got=%0d exp=16", ldr_before); else n_pass++;
    n_checks++; if (!cpu_served || i != 40) $display("FAIL cap_complete got cpu=%b words=%0d exp cpu=1 words=40", cpu_served, i); else n_pass++;
    for (int k = 0; k < 40; k++) begin
      n_checks++; if (mem[256 + k] !== W'(16'hA000 + k)) $display("FAIL cap_mem addr=%0h got=%h exp=%h", 256 + k, mem[256 + k], W'(16'hA000 + k)); else n_pass++;
    end
  endtask

  task automatic test_lock_saturate();
    apply_reset();
    ldr_we = 1; ldr_lock = 1; cpu_we = 0; cpu_lock = 0; cpu_addr = 16'h0200;
    @(negedge clk); ldr_req = 1; ldr_addr = 16'h0200; ldr_wdata = 16'h5A00; #1;
    model_clock();
    for (int k = 0; k < 41; k++) begin
      @(negedge clk);
      ldr_addr = W'(16'h0200 + k); ldr_wdata = W'(16'h5A00 + k);
      cpu_req = (k == 40); #1;
      n_checks++; if ({cpu_gnt, ldr_gnt} !== 2'b01) $display("FAIL sat_run k=%0d got=%b exp=01", k, {cpu_gnt, ldr_gnt}); else n_pass++;
      model_clock();
    end
    @(negedge clk); #1;
    n_checks++; if ({cpu_gnt, ldr_gnt} !== 2'b10) $display("FAIL sat_handoff got=%b exp=10", {cpu_gnt, ldr_gnt}); else n_pass++;
    model_clock();
    @(negedge clk); cpu_req = 0; ldr_req = 0; ldr_lock = 0; #1;
    n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h5A00) $display("FAIL sat_read got=%b %h exp=1 5a00", cpu_rvalid, cpu_rdata); else n_pass++;
    model_clock();
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    @(negedge clk); cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234; #1;
    model_clock();
    @(negedge clk); #1;
    n_checks++; if ({cpu_gnt, mem_we} !== 2'b11) $display("FAIL mid_pre got=%b exp=11", {cpu_gnt, mem_we}); else n_pass++;
    rst_n = 1'b0; #1;
    n_checks++; if ({cpu_gnt, ldr_gnt, mem_we} !== 3'b000) $display("FAIL mid_async got=%b exp=000", {cpu_gnt, ldr_gnt, mem_we}); else n_pass++;
    n_checks++; if (mem_addr !== '0 || mem_wdata !== '0) $display("FAIL mid_bus got=%h %h exp=0 0", mem_addr, mem_wdata); else n_pass++;
    n_checks++; if ({cpu_rvalid, ldr_rvalid} !== 2'b00 || cpu_rdata !== '0) $display("FAIL mid_read got=%b %h exp=00 0", {cpu_rvalid, ldr_rvalid}, cpu_rdata); else n_pass++;
    model_reset();
    @(negedge clk);
    n_checks++; if (mem[32] !== 16'h0000) $display("FAIL mid_mem got=%h exp=0000", mem[32]); else n_pass++;
    cpu_req = 0; rst_n = 1'b1;
    model_clock();
    @(negedge clk); cpu_req = 1; #1;
    n_checks++; if (cpu_gnt !== 1'b0) $display("FAIL mid_relat got=%b exp=0", cpu_gnt); else n_pass++;
    model_clock();
    @(negedge clk); #1;
    n_checks++; if (cpu_gnt !== 1'b1) $display("FAIL mid_regnt got=%b exp=1", cpu_gnt); else n_pass++;
    model_clock();
    @(negedge clk); cpu_req = 0; #1;
    n_checks++; if (mem[32] !== 16'h1234) $display("FAIL mid_rewrite got=%h exp=1234", mem[32]); else n_pass++;
    model_clock();
  endtask

  task automatic test_owner_drop();
    apply_reset();
    @(negedge clk); cpu_req = 1; cpu_we = 1; cpu_lock = 0; cpu_addr = 16'h0030; cpu_wdata = 16'h7777; #1;
    model_clock();
    @(negedge clk); #1;
    n_checks++; if (cpu_gnt !== 1'b1) $display("FAIL drop_gnt got=%b exp=1", cpu_gnt); else n_pass++;
    model_clock();
    @(negedge clk); cpu_req = 0; cpu_wdata = 16'h8888; #1;
    n_checks++; if ({cpu_gnt, mem_we} !== 2'b00 || mem_addr !== 16'h0030) $display("FAIL drop_cycle got=%b%b %h exp=00 0030", cpu_gnt, mem_we, mem_addr); else n_pass++;
    model_clock();
    @(negedge clk); #1;
    n_checks++; if (mem_addr !== '0 || mem_we !== 1'b0) $display("FAIL drop_idle got=%h %b exp=0000 0", mem_addr, mem_we); else n_pass++;
    n_checks++; if (mem[48] !== 16'h7777) $display("FAIL drop_mem got=%h exp=7777", mem[48]); else n_pass++;
    model_clock();
    cpu_we = 0;
  endtask

  task automatic test_random(int cycles);
    bit g0 = 0, g1 = 0;
    logic [2*W:0] eb;
    apply_reset();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (!(cpu_req && !g0 && $urandom_range(0, 15) != 0)) begin
        cpu_req = ($urandom_range(0, 3) != 0); cpu_we = 1'($urandom_range(0, 1));
        cpu_lock = ($urandom_range(0, 3) != 0); cpu_addr = W'($urandom_range(0, 63)); cpu_wdata = W'($urandom);
      end
      if (!(ldr_req && !g1 && $urandom_range(0, 15) != 0)) begin
        ldr_req = ($urandom_range(0, 3) != 0); ldr_we = 1'($urandom_range(0, 1));
        ldr_lock = ($urandom_range(0, 3) != 0); ldr_addr = W'($urandom_range(0, 63)); ldr_wdata = W'($urandom);
      end
      #1;
      eb = exp_bus();
      n_checks++; if ({cpu_gnt, ldr_gnt} !== {exp_gnt(0), exp_gnt(1)}) $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, {cpu_gnt, ldr_gnt}, {exp_gnt(0), exp_gnt(1)}); else n_pass++;
      n_checks++; if ({mem_we, mem_addr, mem_wdata} !== eb) $display("FAIL rnd_bus cyc=%0d got=%h exp=%h", c, {mem_we, mem_addr, mem_wdata}, eb); else n_pass++;
      n_checks++; if ({cpu_rvalid, ldr_rvalid} !== {m_rv[0], m_rv[1]}) $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b%b", c, {cpu_rvalid, ldr_rvalid}, m_rv[0], m_rv[1]); else n_pass++;
      if (m_rv[0]) begin
        n_checks++; if (cpu_rdata !== m_rd[0]) $display("FAIL rnd_cpu_rdata cyc=%0d got=%h exp=%h", c, cpu_rdata, m_rd[0]); else n_pass++;
      end
      if (m_rv[1]) begin
        n_checks++; if (ldr_rdata !== m_rd[1]) $display("FAIL rnd_ldr_rdata cyc=%0d got=%h exp=%h", c, ldr_rdata, m_rd[1]); else n_pass++;
      end
      g0 = exp_gnt(0); g1 = exp_gnt(1);
      model_clock();
    end
    @(negedge clk); cpu_req = 0; ldr_req = 0; #1;
    model_clock();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_tie();
    test_lock_cap();
    test_lock_saturate();
    test_reset_mid_write();
    test_owner_drop();
    test_random(3000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
